// File: rtl/fp16_pkg.sv
// fp16_pkg: FP16 constants and helpers shared by the vector packer and the adder tree.
package fp16_pkg;
    localparam int DW = 16;
    localparam logic [15:0] FP16_ZERO = 16'h0000;
    function automatic logic fp16_is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
    endfunction
endpackage

// File: rtl/fp16_vector_packer_if.sv
// fp16_vector_packer_if: beat stream in, packed vector out; optional nan_seen with FP16_PACKER_NAN_FLAG_EN.
interface fp16_vector_packer_if #(
    parameter int DW = fp16_pkg::DW,
    parameter int N = 128,
    parameter int LANES = 8
);
    localparam int BEATS = N / LANES;
    localparam int BW = $clog2(BEATS + 1);
    logic clear;
    logic elem_valid;
    logic elem_last;
    logic [LANES*DW-1:0] elem_data;
    logic valid_out;
    logic [N*DW-1:0] out_flat;
    logic [BW-1:0] out_beats;
    logic [15:0] vec_count;
`ifdef FP16_PACKER_NAN_FLAG_EN
    logic nan_seen;
`endif
    modport master (
        output clear, elem_valid, elem_last, elem_data,
        input valid_out, out_flat, out_beats, vec_count
`ifdef FP16_PACKER_NAN_FLAG_EN
        , input nan_seen
`endif
    );
    modport slave (
        input clear, elem_valid, elem_last, elem_data,
        output valid_out, out_flat, out_beats, vec_count
`ifdef FP16_PACKER_NAN_FLAG_EN
        , output nan_seen
`endif
    );
endinterface

// File: rtl/fp16_vector_packer.sv
// fp16_vector_packer: packs LANES-wide FP16 beats into an N-element vector, zero-padding short ones.
// Optional FP16_PACKER_NAN_FLAG_EN adds a per-vector nan_seen flag.
module fp16_vector_packer #(
    parameter int DW = fp16_pkg::DW,
    parameter int N = 128,
    parameter int LANES = 8
) (
    input logic clk,
    input logic rst,
    fp16_vector_packer_if.slave bus
);
    import fp16_pkg::*;
    localparam int BEATS = N / LANES;
    localparam int BW = $clog2(BEATS + 1);
    localparam int LW = LANES * DW;
    localparam int BUFN = (BEATS > 1) ? BEATS - 1 : 1;
    logic [BW-1:0] r_cnt;
    logic [LW-1:0] r_buf [BUFN];
    logic r_valid;
    logic [N*DW-1:0] r_flat;
    logic [BW-1:0] r_beats;
    logic [15:0] r_vec;
    logic w_close;
    logic [N*DW-1:0] w_flat;
    assign w_close = bus.elem_valid && (bus.elem_last || r_cnt == BW'(BEATS - 1));
    // The closing beat bypasses the buffer; slots past it are masked to +0.0 since the buffer holds stale beats.
    always_comb begin
        w_flat = '0;
        for (int b = 0; b < BEATS - 1; b++)
            w_flat[b*LW +: LW] = (b < int'(r_cnt)) ? r_buf[b] : (b == int'(r_cnt)) ? bus.elem_data : {LANES{FP16_ZERO[DW-1:0]}};
        w_flat[(BEATS-1)*LW +: LW] = (r_cnt == BW'(BEATS - 1)) ? bus.elem_data : {LANES{FP16_ZERO[DW-1:0]}};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_valid <= 1'b0;
            r_flat <= '0;
            r_beats <= '0;
            r_vec <= '0;
            for (int b = 0; b < BUFN; b++) r_buf[b] <= '0;
        end else begin
            r_valid <= 1'b0;
            if (bus.clear) begin
                r_cnt <= '0;
            end else if (w_close) begin
                r_flat <= w_flat;
                r_beats <= r_cnt + 1'b1;
                r_valid <= 1'b1;
                r_vec <= r_vec + 16'd1;
                r_cnt <= '0;
            end else if (bus.elem_valid) begin
                for (int b = 0; b < BUFN; b++)
                    if (r_cnt == BW'(b)) r_buf[b] <= bus.elem_data;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
    assign bus.valid_out = r_valid;
    assign bus.out_flat = r_flat;
    assign bus.out_beats = r_beats;
    assign bus.vec_count = r_vec;
`ifdef FP16_PACKER_NAN_FLAG_EN
    logic w_beat_nan;
    logic r_sticky;
    logic r_nan;
    always_comb begin
        w_beat_nan = 1'b0;
        for (int l = 0; l < LANES; l++)
            w_beat_nan = w_beat_nan | fp16_is_nan(16'(bus.elem_data[l*DW +: DW]));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= 1'b0;
            r_nan <= 1'b0;
        end else if (bus.clear) begin
            r_sticky <= 1'b0;
        end else if (w_close) begin
            r_nan <= r_sticky | w_beat_nan;
            r_sticky <= 1'b0;
        end else if (bus.elem_valid) begin
            r_sticky <= r_sticky | w_beat_nan;
        end
    end
    assign bus.nan_seen = r_nan;
`endif
endmodule

// File: tb/tb_fp16_vector_packer.sv
// tb_fp16_vector_packer: directed and random scenarios against a queue-based vector model.
module tb_fp16_vector_packer;
    localparam int DW = 16;
    localparam int N = 128;
    localparam int LANES = 8;
    localparam int BEATS = N / LANES;
    localparam int BW = $clog2(BEATS + 1);
    localparam int LW = LANES * DW;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    fp16_vector_packer_if #(.DW(DW), .N(N), .LANES(LANES)) bus();
    fp16_vector_packer #(.DW(DW), .N(N), .LANES(LANES)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int errors = 0;
    logic [LW-1:0] q[$];
    logic m_valid = 1'b0;
    logic [N*DW-1:0] m_flat = '0;
    logic [BW-1:0] m_beats = '0;
    logic [15:0] m_count = '0;
    logic m_nan = 1'b0;

    function automatic logic [LW-1:0] fill(input logic [15:0] v);
        return {LANES{v}};
    endfunction

    function automatic logic [LW-1:0] ramp(input int b);
        logic [LW-1:0] d;
        for (int k = 0; k < LANES; k++) d[k*DW +: DW] = 16'(b * LANES + k);
        return d;
    endfunction

    // Drive one cycle, then advance the model: a vector is the list of beats accepted since the last close.
    task automatic step(input logic r, input logic c, input logic v, input logic l, input logic [LW-1:0] d);
        logic [15:0] e;
        @(negedge clk);
        rst = r;
        bus.clear = c;
        bus.elem_valid = v;
        bus.elem_last = l;
        bus.elem_data = d;
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        if (r) begin
            q.delete();
            m_flat = '0;
            m_beats = '0;
            m_count = '0;
            m_nan = 1'b0;
        end else if (c) begin
            q.delete();
        end else if (v) begin
            q.push_back(d);
            if (l || q.size() == BEATS) begin
                m_valid = 1'b1;
                m_flat = '0;
                m_nan = 1'b0;
                foreach (q[b])
                    for (int k = 0; k < LANES; k++) begin
                        e = q[b][k*DW +: DW];
                        m_flat[(b*LANES+k)*DW +: DW] = e;
                        if (e[14:10] == 5'h1F && e[9:0] != 0) m_nan = 1'b1;
                    end
                m_beats = BW'(q.size());
                m_count = m_count + 16'd1;
                q.delete();
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, '0);
            checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset valid_out got %b exp 0", bus.valid_out); end
            checks++; if (bus.out_flat !== '0) begin errors++; $display("FAIL reset out_flat got nonzero low %h", bus.out_flat[63:0]); end
            checks++; if ({bus.out_beats, bus.vec_count} !== '0) begin errors++; $display("FAIL reset beats/count got %0d/%0d exp 0/0", bus.out_beats, bus.vec_count); end
`ifdef FP16_PACKER_NAN_FLAG_EN
            checks++; if (bus.nan_seen !== 1'b0) begin errors++; $display("FAIL reset nan_seen got %b exp 0", bus.nan_seen); end
`endif
        end
    endtask

    task automatic run_checks(input string nm, input int i);
        checks++; if (bus.valid_out !== m_valid) begin errors++; $display("FAIL %s valid_out cyc %0d got %b exp %b", nm, i, bus.valid_out, m_valid); end
        checks++;
        if (bus.out_flat !== m_flat) begin
            errors++;
            for (int j = 0; j < N; j++)
                if (bus.out_flat[j*DW +: DW] !== m_flat[j*DW +: DW]) begin
                    $display("FAIL %s out_flat cyc %0d elem %0d got %h exp %h", nm, i, j, bus.out_flat[j*DW +: DW], m_flat[j*DW +: DW]);
                    break;
                end
        end
        checks++; if (bus.out_beats !== m_beats) begin errors++; $display("FAIL %s out_beats cyc %0d got %0d exp %0d", nm, i, bus.out_beats, m_beats); end
        checks++; if (bus.vec_count !== m_count) begin errors++; $display("FAIL %s vec_count cyc %0d got %0d exp %0d", nm, i, bus.vec_count, m_count); end
`ifdef FP16_PACKER_NAN_FLAG_EN
        checks++; if (bus.nan_seen !== m_nan) begin errors++; $display("FAIL %s nan_seen cyc %0d got %b exp %b", nm, i, bus.nan_seen, m_nan); end
`endif
    endtask

    task automatic test_full();
        for (int i = 0; i < 18; i++) begin
            step(1'b0, 1'b0, i < BEATS, i == BEATS - 1, ramp(i));
            run_checks("full", i);
            if (i == BEATS - 1) begin
                checks++; if (bus.out_flat[127*DW +: DW] !== 16'h007F || bus.out_beats !== BW'(16))
                    begin errors++; $display("FAIL full last_elem/beats got %h/%0d exp 007f/16", bus.out_flat[127*DW +: DW], bus.out_beats); end
            end
        end
    endtask

    task automatic test_short();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, i < 3, i == 2, fill(16'h3C00));
            run_checks("short", i);
            if (i == 2) begin
                checks++; if (bus.out_flat[23*DW +: DW] !== 16'h3C00 || bus.out_flat[24*DW +: DW] !== 16'h0000 || bus.out_beats !== BW'(3))
                    begin errors++; $display("FAIL short pad got %h/%h/%0d exp 3c00/0000/3", bus.out_flat[23*DW +: DW], bus.out_flat[24*DW +: DW], bus.out_beats); end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2 * BEATS + 1; i++) begin
            step(1'b0, 1'b0, i < 2 * BEATS, 1'b0, fill(i < BEATS ? 16'h3C00 : 16'h4000));
            run_checks("b2b", i);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, i == 5, i <= 6, i == 6, fill(i == 6 ? 16'h4400 : 16'h5555));
            run_checks("clear", i);
            if (i == 6) begin
                checks++; if (bus.out_beats !== BW'(1) || bus.out_flat[7*DW +: DW] !== 16'h4400 || bus.out_flat[8*DW +: DW] !== 16'h0000)
                    begin errors++; $display("FAIL clear one_beat got %0d/%h/%h exp 1/4400/0000", bus.out_beats, bus.out_flat[7*DW +: DW], bus.out_flat[8*DW +: DW]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 28; i++) begin
            step(i == 10, 1'b0, i != 10 && i < 27, 1'b0, fill(i < 10 ? 16'h7777 : 16'h3800));
            run_checks("rstmid", i);
        end
        checks++; if (bus.vec_count !== 16'd1) begin errors++; $display("FAIL rstmid vec_count got %0d exp 1", bus.vec_count); end
    endtask

`ifdef FP16_PACKER_NAN_FLAG_EN
    task automatic test_nan();
        logic [LW-1:0] d;
        for (int i = 0; i < BEATS + 2; i++) begin
            d = fill(16'h3C00);
            if (i == 5) d[0 +: DW] = 16'h7E01;
            step(1'b0, 1'b0, i <= BEATS, i == BEATS, d);
            run_checks("nan", i);
            if (i == BEATS - 1 || i == BEATS) begin
                checks++; if (bus.nan_seen !== (i == BEATS - 1)) begin errors++; $display("FAIL nan flag cyc %0d got %b exp %b", i, bus.nan_seen, i == BEATS - 1); end
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [LW-1:0] d;
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < LANES; k++) d[k*DW +: DW] = ($urandom_range(0, 9) == 0) ? 16'h7C01 : 16'($urandom);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, d);
            run_checks("random", i);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.clear = 1'b0;
        bus.elem_valid = 1'b0;
        bus.elem_last = 1'b0;
        bus.elem_data = '0;
        test_reset();
        test_full();
        test_short();
        test_back_to_back();
        test_clear();
        test_reset_mid();
`ifdef FP16_PACKER_NAN_FLAG_EN
        test_nan();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
